// File: rtl/adder_unit.sv
// ---------------------------------------------------------------------------
// adder_unit
//
// Purpose:
//   Registered ripple-carry adder. Two WIDTH-bit operands plus a carry-in
//   go through a chain of WIDTH full-adder cells. The sum, the carry out of
//   the MSB and the signed-overflow flag are captured in one register stage.
//   Latency is one cycle, and a new add can be accepted every cycle.
//
// Parameters:
//   WIDTH        operand and sum width in bits (1 to 64)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_in_valid   samples i_a, i_b and i_cin when high
//   i_a          operand A (two's complement or unsigned)
//   i_b          operand B (two's complement or unsigned)
//   i_cin        carry-in to bit 0
//   o_y          registered sum, a + b + cin mod 2^WIDTH
//   o_cout       registered carry out of the MSB (unsigned overflow)
//   o_overflow   registered signed overflow
//   o_out_valid  one-cycle pulse when the result registers were loaded
// ---------------------------------------------------------------------------
module adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_y,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;

  logic [WIDTH-1:0] r_y;
  logic             r_cout;
  logic             r_overflow;
  logic             r_out_valid;

  assign w_carry[0] = i_cin;

  // One full-adder cell per bit. Each cell's carry output feeds the next
  // cell, so the critical path is the full WIDTH-stage ripple.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign w_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (i_a[gi] & i_b[gi])
                           | (i_a[gi] & w_carry[gi])
                           | (i_b[gi] & w_carry[gi]);
  end

  // Signed overflow: the carry into the sign bit differs from the carry out
  // of it. For WIDTH=1 the carry into the sign bit is cin itself.
  assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  // The result registers load only on accepted operands and hold otherwise.
  // The valid flag follows i_in_valid every cycle, which gives exactly one
  // pulse per accepted add. Reset wins, so operands presented on the reset
  // edge are discarded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_y         <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= i_in_valid;
      if (i_in_valid) begin
        r_y        <= w_sum;
        r_cout     <= w_carry[WIDTH];
        r_overflow <= w_overflow;
      end
    end
  end

  assign o_y         = r_y;
  assign o_cout      = r_cout;
  assign o_overflow  = r_overflow;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_adder_unit.sv
// ---------------------------------------------------------------------------
// tb_adder_unit
//
// Purpose:
//   Directed bench for adder_unit. It drives a 1-bit instance and an 8-bit
//   instance from a shared clock and reset. Every expected value is a
//   hand-computed constant.
// ---------------------------------------------------------------------------
module tb_adder_unit;

  logic       clk;
  logic       rstN;

  logic       inValid1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic [0:0] y1;
  logic       cout1;
  logic       ovf1;
  logic       outValid1;

  logic       inValid8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic [7:0] y8;
  logic       cout8;
  logic       ovf8;
  logic       outValid8;

  int testsRun;
  int testsFailed;

  adder_unit #(.WIDTH(1)) dut1 (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid1),
    .i_a         (a1),
    .i_b         (b1),
    .i_cin       (cin1),
    .o_y         (y1),
    .o_cout      (cout1),
    .o_overflow  (ovf1),
    .o_out_valid (outValid1)
  );

  adder_unit #(.WIDTH(8)) dut8 (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_in_valid  (inValid8),
    .i_a         (a8),
    .i_b         (b8),
    .i_cin       (cin8),
    .o_y         (y8),
    .o_cout      (cout8),
    .o_overflow  (ovf8),
    .o_out_valid (outValid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are sampled away
  // from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got1;
    logic [10:0] got8;
    rstN = 1'b0;
    inValid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    inValid8 = 1'b1; a8 = 8'd1; b8 = 8'd1; cin8 = 1'b1;
    tick();
    tick();
    got1 = {y1, cout1, ovf1, outValid1};
    testsRun++;
    if (got1 !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_w1: got {y,cout,ovf,ov}=%b expected 0000", got1);
    end
    got8 = {y8, cout8, ovf8, outValid8};
    testsRun++;
    if (got8 !== 11'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_w8: got {y,cout,ovf,ov}=%h expected 000", got8);
    end
    rstN = 1'b1;
    inValid1 = 1'b0;
    inValid8 = 1'b0;
    tick();
  endtask

  task automatic test_w1_exhaustive();
    logic [2:0] vecs [8];
    logic [2:0] exps [8];
    logic [3:0] got;
    // {a,b,cin} -> {y,cout,overflow}
    vecs = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    exps = '{3'b000, 3'b100, 3'b100, 3'b011, 3'b101, 3'b010, 3'b010, 3'b110};
    inValid1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a1[0] = vecs[i][2];
      b1[0] = vecs[i][1];
      cin1  = vecs[i][0];
      tick();
      got = {y1, cout1, ovf1, outValid1};
      testsRun++;
      if (got !== {exps[i], 1'b1}) begin
        testsFailed++;
        $display("[TB] FAIL w1_abc_%b: got {y,cout,ovf,ov}=%b expected %b",
                 vecs[i], got, {exps[i], 1'b1});
      end
    end
    inValid1 = 1'b0;
    tick();
  endtask

  task automatic test_w8_signed();
    logic [16:0] vecs [4];
    logic [9:0]  exps [4];
    logic [10:0] got;
    // {a,b,cin} -> {y,cout,overflow}; the last entry is the full carry chain
    vecs = '{{8'h7F, 8'h01, 1'b0}, {8'hFF, 8'h01, 1'b0},
             {8'h80, 8'h80, 1'b0}, {8'hFF, 8'h00, 1'b1}};
    exps = '{{8'h80, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b0},
             {8'h00, 1'b1, 1'b1}, {8'h00, 1'b1, 1'b0}};
    inValid8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a8, b8, cin8} = vecs[i];
      tick();
      got = {y8, cout8, ovf8, outValid8};
      testsRun++;
      if (got !== {exps[i], 1'b1}) begin
        testsFailed++;
        $display("[TB] FAIL w8_case%0d: got {y,cout,ovf,ov}=%h expected %h",
                 i, got, {exps[i], 1'b1});
      end
    end
    inValid8 = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    inValid8 = 1'b1; a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0;
    tick();
    testsRun++;
    if (y8 !== 8'd7 || outValid8 !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hold_load: got y=%0d ov=%b expected y=7 ov=1", y8, outValid8);
    end
    inValid8 = 1'b0; a8 = 8'h55; b8 = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++;
      if (y8 !== 8'd7 || outValid8 !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL hold_cycle%0d: got y=%0d ov=%b expected y=7 ov=0",
                 i, y8, outValid8);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [10:0] got;
    // The hold test leaves y=7 in the register, so clearing is observable.
    inValid8 = 1'b1; a8 = 8'd5; b8 = 8'd6; cin8 = 1'b0;
    rstN = 1'b0;
    tick();
    got = {y8, cout8, ovf8, outValid8};
    testsRun++;
    if (got !== 11'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_clear: got {y,cout,ovf,ov}=%h expected 000", got);
    end
    rstN = 1'b1;
    a8 = 8'd1; b8 = 8'd1;
    tick();
    got = {y8, cout8, ovf8, outValid8};
    testsRun++;
    if (got !== {8'd2, 1'b0, 1'b0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL midreset_resume: got {y,cout,ovf,ov}=%h expected %h",
               got, {8'd2, 1'b0, 1'b0, 1'b1});
    end
    inValid8 = 1'b0;
    tick();
    testsRun++;
    if (outValid8 !== 1'b0 || y8 !== 8'd2) begin
      testsFailed++;
      $display("[TB] FAIL midreset_idle: got y=%0d ov=%b expected y=2 ov=0", y8, outValid8);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rstN     = 1'b0;
    inValid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    inValid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    #2;
    test_reset();
    test_w1_exhaustive();
    test_w8_signed();
    test_hold();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
